// File: rtl/mic_pcm_fifo_core_pkg.sv
// Shared constants for the PCM FIFO MMIO slot: register offsets and STATUS bit positions.
package mic_pcm_fifo_core_pkg;

  // Slot register offsets
  localparam logic [4:0] REG_DATA   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd1;
  localparam logic [4:0] REG_POP    = 5'd2;
  localparam logic [4:0] REG_CTRL   = 5'd3;
  localparam logic [4:0] REG_WMARK  = 5'd4;

  // STATUS bit positions (count occupies [ADDR_W:0])
  localparam int unsigned ST_EMPTY = 16;
  localparam int unsigned ST_FULL  = 17;
  localparam int unsigned ST_OVF   = 18;
  localparam int unsigned ST_EN    = 19;
  localparam int unsigned ST_IRQ   = 20;

  // CTRL bit positions
  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_CLR = 1;

endpackage

// File: rtl/pcm_sync_fifo.sv
// First-word-fall-through synchronous FIFO for PCM samples with push/pop/flush.
// Handshake: a push is taken when push=1 and the FIFO is not full, or when it is
// full and a pop is taken in the same cycle; a pop is taken when pop=1 and the
// FIFO is not empty. flush dominates both and empties the FIFO.
module pcm_sync_fifo #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   count_next,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Qualify strobes against occupancy and compute the next occupancy
  always_comb begin
    do_pop     = pop && !empty && !flush;
    do_push    = push && (!full || do_pop) && !flush;
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end
  end

  // Pointer and occupancy registers; reset and flush both empty the FIFO
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
    end
  end

  // Sample storage, kept reset-free so it maps to distributed RAM
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mic_pcm_fifo_core.sv
// MMIO slot core buffering decimated PCM samples for software readout:
// register decode, enable/overflow/watermark registers, irq and read mux.
module mic_pcm_fifo_core
  import mic_pcm_fifo_core_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              read,
  input  logic              write,
  input  logic [4:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  input  logic [DATA_W-1:0] pcm_sample,
  input  logic              pcm_valid,
  output logic              fifo_irq
);

  logic              enable;
  logic              overflow;
  logic [ADDR_W:0]   wmark;
  logic              wr_en;
  logic              pop_req;
  logic              push_req;
  logic              clear;
  logic [DATA_W-1:0] head;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;
  logic              full;
  logic              empty;
  logic [31:0]       status;
  logic              unused_bits;

  assign wr_en    = cs && write;
  assign pop_req  = wr_en && (addr == REG_POP);
  assign clear    = wr_en && (addr == REG_CTRL) && wr_data[CTRL_CLR];
  assign push_req = pcm_valid && enable;

  // Reads have no side effects, and only the low data bits reach registers
  assign unused_bits = ^{read, wr_data[31:ADDR_W+1]};

  pcm_sync_fifo #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .pop       (pop_req),
    .flush     (clear),
    .din       (pcm_sample),
    .dout      (head),
    .count     (count),
    .count_next(count_next),
    .full      (full),
    .empty     (empty)
  );

  // Control registers: enable level, watermark, sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      enable   <= 1'b0;
      wmark    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en && (addr == REG_CTRL))  enable <= wr_data[CTRL_EN];
      if (wr_en && (addr == REG_WMARK)) wmark  <= wr_data[ADDR_W:0];
      if (clear) begin
        overflow <= 1'b0;
      end else if (push_req && full && !pop_req) begin
        overflow <= 1'b1;
      end
    end
  end

  // Watermark interrupt, tracking the occupancy that takes effect this edge
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_irq <= 1'b0;
    end else begin
      fifo_irq <= (wmark != '0) && (count_next >= wmark);
    end
  end

  // STATUS word assembly
  always_comb begin
    status            = '0;
    status[ADDR_W:0]  = count;
    status[ST_EMPTY]  = empty;
    status[ST_FULL]   = full;
    status[ST_OVF]    = overflow;
    status[ST_EN]     = enable;
    status[ST_IRQ]    = fifo_irq;
  end

  // Read mux over registered state; unmapped offsets read zero
  always_comb begin
    rd_data = '0;
    case (addr)
      REG_DATA:   rd_data = empty ? 32'd0 : {{(32-DATA_W){head[DATA_W-1]}}, head};
      REG_STATUS: rd_data = status;
      REG_CTRL:   rd_data[CTRL_EN] = enable;
      REG_WMARK:  rd_data[ADDR_W:0] = wmark;
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mic_pcm_fifo_core.sv
// Self-checking bench for mic_pcm_fifo_core: a register-level vector table,
// hand-written corner sequences and a randomized push/pop stream against a queue model.
module tb_mic_pcm_fifo_core;
  import mic_pcm_fifo_core_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [15:0] pcm_sample;
  logic        pcm_valid;
  logic        fifo_irq;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] exp_q[$];
  bit          m_en;
  bit          m_ovf;
  logic [6:0]  m_wm;

  typedef struct {
    int          op;     // 0 idle, 1 register write, 2 push, 3 pop
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  mic_pcm_fifo_core dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .read      (read),
    .write     (write),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .pcm_sample(pcm_sample),
    .pcm_valid (pcm_valid),
    .fifo_irq  (fifo_irq)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    addr = a;
    read = 1'b1;
    #1;
    v = rd_data;
    read = 1'b0;
  endtask

  // Model of one cycle of pop request / sample strobe
  task automatic model_step(input bit do_pop, input bit do_push, input logic [15:0] s);
    bit pop_ok;
    bit push_ok;
    pop_ok  = do_pop && (exp_q.size() > 0);
    push_ok = 1'b0;
    if (do_push && m_en) begin
      if (exp_q.size() < 64 || pop_ok) push_ok = 1'b1;
      else m_ovf = 1'b1;
    end
    if (pop_ok) void'(exp_q.pop_front());
    if (push_ok) exp_q.push_back(s);
  endtask

  // Driver: one cycle with optional POP write and optional sample strobe
  task automatic cycle(input bit do_pop, input bit do_push, input logic [15:0] s);
    @(negedge clk);
    cs = 1'b1; write = do_pop; addr = REG_POP; wr_data = $urandom;
    pcm_valid = do_push; pcm_sample = s;
    @(posedge clk);
    #1;
    write = 1'b0; pcm_valid = 1'b0;
    model_step(do_pop, do_push, s);
  endtask

  // Driver: register write with an optional concurrent sample strobe
  task automatic reg_wr(input logic [4:0] a, input logic [31:0] d, input bit pv, input logic [15:0] s);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    pcm_valid = pv; pcm_sample = s;
    @(posedge clk);
    #1;
    write = 1'b0; pcm_valid = 1'b0;
    if (a == REG_CTRL && d[1]) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_en  = d[0];
    end else begin
      model_step(1'b0, pv, s);
      if (a == REG_CTRL)  m_en = d[0];
      if (a == REG_WMARK) m_wm = d[6:0];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cs = 1'b1; write = 1'b1; addr = REG_CTRL; wr_data = 32'h1;
    pcm_valid = 1'b1; pcm_sample = 16'h1234;
    @(posedge clk);
    #1;
    reset = 1'b0; write = 1'b0; pcm_valid = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0; m_en = 1'b0; m_wm = '0;
  endtask

  // Scoreboard compare of DATA, STATUS and irq against the model
  task automatic check_state(input string tag);
    logic [31:0] v;
    logic [31:0] exp_status;
    logic [31:0] exp_data;
    logic        exp_irq;
    int          n;
    n = exp_q.size();
    exp_irq = (m_wm != 0) && (n >= int'(m_wm));
    exp_status = 32'(n);
    exp_status[ST_EMPTY] = (n == 0);
    exp_status[ST_FULL]  = (n == 64);
    exp_status[ST_OVF]   = m_ovf;
    exp_status[ST_EN]    = m_en;
    exp_status[ST_IRQ]   = exp_irq;
    exp_data = (n == 0) ? 32'd0 : {{16{exp_q[0][15]}}, exp_q[0]};
    rd(REG_STATUS, v);
    check({tag, "_status"}, v, exp_status);
    rd(REG_DATA, v);
    check({tag, "_data"}, v, exp_data);
    check({tag, "_irq"}, {31'd0, fifo_irq}, {31'd0, exp_irq});
  endtask

  initial begin
    logic [31:0] v;
    logic [15:0] first_s;
    logic [15:0] second_s;
    logic [15:0] s;

    // Vector table: action, then readback of one register
    vecs[0]  = '{1, REG_CTRL,  32'h1,        REG_CTRL,   32'h1};
    vecs[1]  = '{2, 5'd0,      32'hFFFB,     REG_DATA,   32'hFFFFFFFB};
    vecs[2]  = '{2, 5'd0,      32'h0007,     REG_STATUS, 32'h00080002};
    vecs[3]  = '{2, 5'd0,      32'h7FFF,     REG_STATUS, 32'h00080003};
    vecs[4]  = '{0, 5'd0,      32'h0,        REG_DATA,   32'hFFFFFFFB};
    vecs[5]  = '{3, 5'd0,      32'h0,        REG_DATA,   32'h00000007};
    vecs[6]  = '{3, 5'd0,      32'h0,        REG_DATA,   32'h00007FFF};
    vecs[7]  = '{3, 5'd0,      32'h0,        REG_STATUS, 32'h00090000};
    vecs[8]  = '{3, 5'd0,      32'h0,        REG_STATUS, 32'h00090000};
    vecs[9]  = '{1, REG_CTRL,  32'h0,        REG_CTRL,   32'h0};
    vecs[10] = '{2, 5'd0,      32'h0063,     REG_STATUS, 32'h00010000};
    vecs[11] = '{1, REG_WMARK, 32'h5,        REG_WMARK,  32'h5};
    vecs[12] = '{0, 5'd0,      32'h0,        5'd7,       32'h0};
    vecs[13] = '{1, REG_WMARK, 32'h0,        REG_WMARK,  32'h0};
    vecs[14] = '{1, 5'd9,      32'hFFFFFFFF, REG_CTRL,   32'h0};
    vecs[15] = '{0, 5'd0,      32'h0,        REG_DATA,   32'h0};

    // Reset block
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0;
    wr_data = '0; pcm_sample = '0; pcm_valid = 1'b0;
    m_en = 1'b0; m_ovf = 1'b0; m_wm = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    rd(REG_STATUS, v); check("reset_status", v, 32'h00010000);
    rd(REG_DATA, v);   check("reset_data", v, 32'h0);
    check("reset_irq", {31'd0, fifo_irq}, 32'h0);

    // Table-driven register sequence
    for (int i = 0; i < 16; i++) begin
      case (vecs[i].op)
        1: reg_wr(vecs[i].waddr, vecs[i].wdata, 1'b0, 16'h0);
        2: cycle(1'b0, 1'b1, vecs[i].wdata[15:0]);
        3: cycle(1'b1, 1'b0, 16'h0);
        default: cycle(1'b0, 1'b0, 16'h0);
      endcase
      rd(vecs[i].raddr, v);
      check($sformatf("vec%0d", i), v, vecs[i].exp);
    end

    // Disabled: strobes ignored
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 16'($urandom));
    rd(REG_STATUS, v); check("disabled_status", v, 32'h00010000);

    // Fill to full, then overflow, then simultaneous push+pop at full
    reg_wr(REG_CTRL, 32'h1, 1'b0, 16'h0);
    first_s = 16'($urandom);
    second_s = 16'($urandom);
    cycle(1'b0, 1'b1, first_s);
    cycle(1'b0, 1'b1, second_s);
    for (int i = 2; i < 64; i++) begin
      cycle(1'b0, 1'b1, 16'($urandom));
      check_state($sformatf("fill%0d", i));
    end
    rd(REG_STATUS, v); check("full_status", v, 32'h000A0040);
    cycle(1'b0, 1'b1, 16'hABCD);
    rd(REG_STATUS, v); check("ovf_status", v, 32'h000E0040);
    rd(REG_DATA, v);   check("ovf_head", v, {{16{first_s[15]}}, first_s});
    cycle(1'b1, 1'b1, 16'h1357);
    rd(REG_STATUS, v); check("full_pushpop_status", v, 32'h000E0040);
    rd(REG_DATA, v);   check("full_pushpop_head", v, {{16{second_s[15]}}, second_s});
    check_state("full_pushpop");

    // Empty: lone pop, then pop+push
    reg_wr(REG_CTRL, 32'h3, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0);
    rd(REG_STATUS, v); check("empty_pop_status", v, 32'h00090000);
    cycle(1'b1, 1'b1, 16'd123);
    rd(REG_STATUS, v); check("empty_pushpop_status", v, 32'h00080001);
    rd(REG_DATA, v);   check("empty_pushpop_data", v, 32'd123);

    // Watermark interrupt
    reg_wr(REG_CTRL, 32'h3, 1'b0, 16'h0);
    reg_wr(REG_WMARK, 32'h4, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 16'(i + 1));
      check($sformatf("wm_below%0d_irq", i), {31'd0, fifo_irq}, 32'h0);
    end
    cycle(1'b0, 1'b1, 16'd4);
    check("wm_reach_irq", {31'd0, fifo_irq}, 32'h1);
    rd(REG_STATUS, v); check("wm_reach_status", v, 32'h00180004);
    cycle(1'b1, 1'b0, 16'h0);
    check("wm_pop_irq", {31'd0, fifo_irq}, 32'h0);

    // Randomized stream against the queue model
    for (int i = 0; i < 250; i++) begin
      cycle($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 6, 16'($urandom));
      check_state($sformatf("rand%0d", i));
    end

    // Clear with a concurrent push after overflow
    reg_wr(REG_CTRL, 32'h3, 1'b0, 16'h0);
    for (int i = 0; i < 65; i++) cycle(1'b0, 1'b1, 16'($urandom));
    rd(REG_STATUS, v); check("pre_clear_status", v, 32'h001E0040);
    reg_wr(REG_CTRL, 32'h3, 1'b1, 16'h5555);
    rd(REG_STATUS, v); check("clear_status", v, 32'h00090000);
    check_state("clear");

    // Reset in mid-stream
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'($urandom));
    do_reset();
    rd(REG_STATUS, v); check("midreset_status", v, 32'h00010000);
    rd(REG_CTRL, v);   check("midreset_ctrl", v, 32'h0);
    rd(REG_WMARK, v);  check("midreset_wmark", v, 32'h0);
    rd(REG_DATA, v);   check("midreset_data", v, 32'h0);
    check("midreset_irq", {31'd0, fifo_irq}, 32'h0);
    cycle(1'b0, 1'b1, 16'h0042);
    check_state("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
